// File: rtl/booth_pkg.sv
// booth_pkg -- shared constants for the radix-2 Booth multiplier datapath.
//   BOOTH_WIDTH : default operand width (the control unit runs exactly 3 steps)
//   Q_*         : encodings of q = {Q[0], Q_1} seen by the control unit
package booth_pkg;
  localparam int BOOTH_WIDTH = 3;

  localparam logic [1:0] Q_SHIFT0 = 2'b00;  // shift only
  localparam logic [1:0] Q_ADD    = 2'b01;  // A <= A + M, then shift
  localparam logic [1:0] Q_SUB    = 2'b10;  // A <= A - M, then shift
  localparam logic [1:0] Q_SHIFT1 = 2'b11;  // shift only
endpackage

// File: rtl/booth_addsub.sv
// booth_addsub -- combinational adder/subtractor for the Booth accumulator.
//   a, b : W-bit operands
//   sub  : 1 = a - b, 0 = a + b
//   sum  : W-bit result, modulo 2^W
module booth_addsub #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);
  assign sum = sub ? (a - b) : (a + b);
endmodule

// File: rtl/booth_datapath.sv
// booth_datapath -- register datapath of a radix-2 Booth multiplier.
// Holds M, A, Q, Q_1; the external control unit sequences it through the
// load / add-sub / shift strobes and watches q = {Q[0], Q_1}.
//   clk, rst_n            : clock, synchronous active-low reset
//   mcand, mplier         : signed operands (loaded on cargaM / cargaQ)
//   resta                 : 1 = subtract M on cargaA, 0 = add M
//   desp                  : arithmetic right shift of {A,Q,Q_1}
//   cargaA/cargaQ/cargaM  : load strobes
//   fin                   : control unit done level
//   q                     : {Q[0], Q_1}
//   prod, prod_valid      : signed product and its valid flag
//   prod_ack              : consumer accepts product
// Build option: BOOTH_PROD_HOLD_EN -- when defined, the product is captured
// on the rising edge of fin into a register held until prod_ack; otherwise
// prod is the live {A,Q} view and prod_valid follows fin.
module booth_datapath
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  input  logic               resta,
  input  logic               desp,
  input  logic               cargaA,
  input  logic               cargaQ,
  input  logic               cargaM,
  input  logic               fin,
  output logic [1:0]         q,
  output logic [2*WIDTH-1:0] prod,
  output logic               prod_valid,
  input  logic               prod_ack
);
  logic [WIDTH:0]     r_m;
  logic [WIDTH:0]     r_a;
  logic [WIDTH-1:0]   r_q;
  logic               r_q1;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod_now;

  // One extra accumulator bit so -M of the most negative multiplicand fits.
  booth_addsub #(.W(WIDTH+1)) u_addsub (
    .a   (r_a),
    .b   (r_m),
    .sub (resta),
    .sum (w_sum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m  <= '0;
      r_a  <= '0;
      r_q  <= '0;
      r_q1 <= 1'b0;
    end else if (cargaQ || cargaM) begin
      if (cargaM) r_m <= {mcand[WIDTH-1], mcand};
      if (cargaQ) begin
        r_q  <= mplier;
        r_a  <= '0;
        r_q1 <= 1'b0;
      end
    end else if (cargaA) begin
      r_a <= w_sum;
    end else if (desp) begin
      // Arithmetic shift of the whole {A,Q,Q_1} chain.
      {r_a, r_q, r_q1} <= {r_a[WIDTH], r_a, r_q};
    end
  end

  assign q          = {r_q[0], r_q1};
  assign w_prod_now = {r_a[WIDTH-1:0], r_q};

`ifdef BOOTH_PROD_HOLD_EN
  logic               r_fin_d;
  logic [2*WIDTH-1:0] r_prod;
  logic               r_prod_valid;
  logic               w_capture;

  // Only the 0->1 transition of fin captures, so a held fin is one result.
  assign w_capture = fin && !r_fin_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fin_d      <= 1'b0;
      r_prod       <= '0;
      r_prod_valid <= 1'b0;
    end else begin
      r_fin_d <= fin;
      if (w_capture) begin
        // Capture beats a simultaneous ack: the new result stays valid.
        r_prod       <= w_prod_now;
        r_prod_valid <= 1'b1;
      end else if (prod_ack && r_prod_valid) begin
        r_prod_valid <= 1'b0;
      end
    end
  end

  assign prod       = r_prod;
  assign prod_valid = r_prod_valid;
`else
  logic w_unused_ack;
  assign w_unused_ack = prod_ack;
  assign prod         = w_prod_now;
  assign prod_valid   = fin;
`endif
endmodule

// File: doc/booth_datapath.md
BOOTH_DATAPATH -- requirements
Module: booth_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 3, operand width in bits; the Booth control unit issues exactly 3 iterations, so WIDTH=3 is the only integrated value.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port mcand  input  WIDTH  signed multiplicand, sampled on cargaM.
REQ-005 SHALL have port mplier  input  WIDTH  signed multiplier, sampled on cargaQ.
REQ-006 SHALL have port resta  input  1  1 = subtract M, 0 = add M, meaningful only with cargaA.
REQ-007 SHALL have port desp  input  1  arithmetic right shift of {A,Q,Q_1}.
REQ-008 SHALL have ports cargaA, cargaQ, cargaM  input  1 each  load strobes from the control unit.
REQ-009 SHALL have port fin  input  1  control unit done level.
REQ-010 SHALL have port q  output  2  {Q[0], Q_1}, fed back to the control unit.
REQ-011 SHALL have port prod  output  2*WIDTH  signed product.
REQ-012 SHALL have port prod_valid  output  1  product available.
REQ-013 SHALL have port prod_ack  input  1  consumer accepts product.

Function
REQ-014 SHALL hold registers M (WIDTH+1, sign-extended), A (WIDTH+1), Q (WIDTH), Q_1 (1).
REQ-015 SHALL, on cargaM, load M <= sign-extended mcand.
REQ-016 SHALL, on cargaQ, load Q <= mplier, A <= 0 and Q_1 <= 0.
REQ-017 SHALL, on cargaA, load A <= A+M (resta=0) or A-M (resta=1), modulo 2^(WIDTH+1); no other register changes.
REQ-018 SHALL, on desp, shift {A,Q,Q_1} right by one, replicating A's MSB.
REQ-019 SHALL apply priority cargaQ/cargaM > cargaA > desp; if cargaA and desp are both high, only cargaA takes effect.
REQ-020 SHALL drive q combinationally from the registers; q is valid in the same cycle the register state becomes visible.
REQ-021 SHALL capture the product {A[WIDTH-1:0],Q} into the prod output register when it detects a rising edge of fin (fin=1 while the registered fin_d=0); prod_valid rises 1 cycle after fin rises.
REQ-022 SHALL keep prod_valid and prod stable until prod_ack=1 is sampled while prod_valid=1; prod_valid clears the next cycle.
REQ-023 SHALL, when a capture and an ack happen in the same cycle, let the capture win: prod updates and prod_valid stays 1.
REQ-024 SHALL leave prod and prod_valid unchanged on a new cargaQ/cargaM (a new operation does not discard an unacknowledged result).
REQ-025 SHALL treat a sustained fin=1 as a single capture.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge, clear M, A, Q, Q_1, fin_d and prod to 0 and set prod_valid to 0; q therefore reads 2'b00.
REQ-027 SHALL let reset override every strobe, including mid-operation; after release, nothing happens until the next cargaQ/cargaM.

Configuration
REQ-028 SHALL support macro BOOTH_PROD_HOLD_EN; when it is defined, REQ-021..REQ-025 apply.
REQ-029 SHALL, when BOOTH_PROD_HOLD_EN is undefined, drive prod = {A[WIDTH-1:0],Q} combinationally and prod_valid = fin, ignore prod_ack, and omit the hold register; the port list is identical in both builds.

Structure
REQ-030 SHALL place the default WIDTH constant and the q encodings (00/11 shift only, 01 add, 10 subtract) in a shared package booth_pkg.
REQ-031 SHALL instantiate one combinational sub-module, booth_addsub (WIDTH+1 bits, inputs a, b, sub; output sum).

Verification
REQ-032 SHALL cover: mcand=3, mplier=-2 (3'b110) driven by the control unit -> prod=6'b111010 (-6) and prod_valid=1, one cycle after fin rises.
REQ-033 SHALL cover: mcand=-4, mplier=-4 -> prod=6'b010000 (+16), which proves the WIDTH+1 accumulator.
REQ-034 SHALL cover: mcand=3, mplier=3 -> q sequence after load is 10, 11, 01 at the decision states; prod=6'b001001.
REQ-035 SHALL cover: prod_ack held low for 5 cycles and a new cargaQ issued -> prod and prod_valid unchanged; prod_ack=1 -> prod_valid=0 the next cycle.
REQ-036 SHALL cover: rst_n=0 asserted during the second iteration -> all registers 0, q=00 and prod_valid=0 at the next edge; a subsequent full run gives the correct product.
